// File: rtl/vote_pkg.sv
// Shared constants and helpers for the vote detector pipeline.
package vote_pkg;

  localparam logic VOTE_MINORITY = 1'b0;
  localparam logic VOTE_MAJORITY = 1'b1;

  // Width needed to hold a count of 0..n.
  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/vote_popcount.sv
// Combinational population count of an N_IN-bit vector.
module vote_popcount
  import vote_pkg::*;
#(
  parameter  int unsigned N_IN = 3,
  localparam int unsigned CW   = cnt_w(N_IN)
) (
  input  logic [N_IN-1:0] in_bits,
  output logic [CW-1:0]   count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < int'(N_IN); i++) begin
      count = count + CW'(in_bits[i]);
    end
  end

endmodule

// File: rtl/vote_detect_pipe.sv
// Two-stage minority/majority/tie detector with valid/ready handshakes and a debounce filter.
// Optional flagged-result statistics counter enabled by defining VOTE_STATS_EN.
module vote_detect_pipe
  import vote_pkg::*;
#(
  parameter  int unsigned N_IN    = 3,
  parameter  int unsigned PERSIST = 1,
  parameter  int unsigned CNT_W   = 16,
  localparam int unsigned CW      = cnt_w(N_IN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N_IN-1:0] in_bits,
  input  logic            mode,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_flag,
  output logic            out_tie,
  output logic [CW-1:0]   out_count,
`ifdef VOTE_STATS_EN
  input  logic            stat_clr,
  output logic [CNT_W-1:0] stat_flag_cnt,
`endif
  output logic            filt_flag
);

  localparam int unsigned WW = CW + 1;
  localparam int unsigned PW = 8;

  logic          s1_valid_q, s1_valid_d;
  logic [CW-1:0] s1_cnt_q, s1_cnt_d;
  logic          s1_mode_q, s1_mode_d;
  logic          out_valid_q, out_valid_d;
  logic          out_flag_q, out_flag_d;
  logic          out_tie_q, out_tie_d;
  logic [CW-1:0] out_count_q, out_count_d;
  logic          filt_q, filt_d;
  logic [PW-1:0] pcnt_q, pcnt_d;

  logic [CW-1:0] pop_cnt;
  logic          s1_load, s2_load, accept, out_hs;
  logic [WW-1:0] ones_x2, n_w;
  logic          is_min, is_maj, is_tie;

  vote_popcount #(
    .N_IN(N_IN)
  ) u_popcount (
    .in_bits(in_bits),
    .count  (pop_cnt)
  );

  // Bubble-collapsing control: a stage loads when empty or when its successor moves on.
  assign s2_load  = !out_valid_q || out_ready;
  assign s1_load  = !s1_valid_q || s2_load;
  assign in_ready = s1_load;
  assign accept   = in_valid && s1_load;
  assign out_hs   = out_valid_q && out_ready;

  assign ones_x2 = {s1_cnt_q, 1'b0};
  assign n_w     = WW'(N_IN);
  assign is_min  = ones_x2 < n_w;
  assign is_maj  = ones_x2 > n_w;
  assign is_tie  = ones_x2 == n_w;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_cnt_d   = s1_cnt_q;
    s1_mode_d  = s1_mode_q;
    if (s1_load) begin
      s1_valid_d = accept;
      if (accept) begin
        s1_cnt_d  = pop_cnt;
        s1_mode_d = mode;
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_flag_d  = out_flag_q;
    out_tie_d   = out_tie_q;
    out_count_d = out_count_q;
    if (s2_load) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_count_d = s1_cnt_q;
        out_tie_d   = is_tie;
        unique case (s1_mode_q)
          VOTE_MINORITY: out_flag_d = is_min;
          VOTE_MAJORITY: out_flag_d = is_maj;
        endcase
      end
    end
  end

  // Debounce: count consecutive disagreeing handshakes, flip once PERSIST is reached.
  always_comb begin
    filt_d = filt_q;
    pcnt_d = pcnt_q;
    if (out_hs) begin
      if (out_flag_q == filt_q) begin
        pcnt_d = '0;
      end else if (32'(pcnt_q) + 32'd1 >= PERSIST) begin
        filt_d = out_flag_q;
        pcnt_d = '0;
      end else begin
        pcnt_d = pcnt_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_cnt_q    <= '0;
      s1_mode_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_flag_q  <= 1'b0;
      out_tie_q   <= 1'b0;
      out_count_q <= '0;
      filt_q      <= 1'b0;
      pcnt_q      <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_cnt_q    <= s1_cnt_d;
      s1_mode_q   <= s1_mode_d;
      out_valid_q <= out_valid_d;
      out_flag_q  <= out_flag_d;
      out_tie_q   <= out_tie_d;
      out_count_q <= out_count_d;
      filt_q      <= filt_d;
      pcnt_q      <= pcnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_flag  = out_flag_q;
  assign out_tie   = out_tie_q;
  assign out_count = out_count_q;
  assign filt_flag = filt_q;

`ifdef VOTE_STATS_EN
  logic [CNT_W-1:0] stat_q, stat_d;

  // Clear has priority over a same-cycle increment; the count saturates at all-ones.
  always_comb begin
    stat_d = stat_q;
    if (stat_clr) begin
      stat_d = '0;
    end else if (out_hs && out_flag_q && !(&stat_q)) begin
      stat_d = stat_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_q <= '0;
    end else begin
      stat_q <= stat_d;
    end
  end

  assign stat_flag_cnt = stat_q;
`else
  logic unused_cnt_w;
  assign unused_cnt_w = ^CNT_W;
`endif

endmodule
